// File: rtl/ps2_input_sequencer_if.sv
// ----------------------------------------------------------------------------
// ps2_input_sequencer_if
// Bundles the byte stream from the PS2 receiver, the decoded key state and
// movement ticks, and the START/PAUSE event FIFO handshake.
//   master : producer of bytes / consumer of events (e.g. testbench, game)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface ps2_input_sequencer_if;
  logic [7:0] code;          // scan code byte
  logic       valid;         // byte-valid level, new byte on rising edge
  logic [3:0] key_held;      // {p2_dn, p2_up, p1_dn, p1_up}
  logic       p1_up_tick;
  logic       p1_dn_tick;
  logic       p2_up_tick;
  logic       p2_dn_tick;
  logic       evt_valid;     // event FIFO non-empty
  logic       evt_code;      // head event: 0 = START, 1 = PAUSE
  logic       evt_ready;     // consumer pop
  logic       evt_overflow;  // sticky drop flag

  modport master (
    output code, valid, evt_ready,
    input  key_held, p1_up_tick, p1_dn_tick, p2_up_tick, p2_dn_tick,
           evt_valid, evt_code, evt_overflow
  );

  modport slave (
    input  code, valid, evt_ready,
    output key_held, p1_up_tick, p1_dn_tick, p2_up_tick, p2_dn_tick,
           evt_valid, evt_code, evt_overflow
  );
endinterface

// File: rtl/ps2_input_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_input_sequencer
// Decodes PS2 set-2 scan codes into held-key state for two paddle players,
// generates periodic movement ticks from the resolved direction of each
// player, and queues START/PAUSE press events in a 4-entry FIFO.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - ps2_input_sequencer_if.slave (byte input, key state, ticks, events)
// ----------------------------------------------------------------------------
module ps2_input_sequencer #(
  parameter int TICK_COUNT = 12500000,
  parameter int TIMEOUT    = 131072
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_input_sequencer_if.slave  bus
);

  localparam logic [7:0] P1_UP_KEY = 8'h1D;
  localparam logic [7:0] P1_DN_KEY = 8'h1B;
  localparam logic [7:0] P2_UP_KEY = 8'h44;
  localparam logic [7:0] P2_DN_KEY = 8'h4B;
  localparam logic [7:0] START_KEY = 8'h29;
  localparam logic [7:0] PAUSE_KEY = 8'h4D;
  localparam logic [7:0] BRK_CODE  = 8'hF0;
  localparam logic [7:0] EXT_CODE  = 8'hE0;

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int OW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state_q,      state_d;
  logic [OW-1:0] to_cnt_q,     to_cnt_d;
  logic [TW-1:0] tick_cnt_q,   tick_cnt_d;
  logic          valid_q;      // delayed copy of valid for edge detection
  logic [3:0]    key_held_q,   key_held_d;
  logic          p1_last_q,    p1_last_d;    // 0 = up pressed last, 1 = down
  logic          p2_last_q,    p2_last_d;
  logic          start_held_q, start_held_d;
  logic          pause_held_q, pause_held_d;
  logic [3:0]    fifo_q,       fifo_d;
  logic [1:0]    wr_ptr_q,     wr_ptr_d;
  logic [1:0]    rd_ptr_q,     rd_ptr_d;
  logic [2:0]    count_q,      count_d;
  logic          overflow_q,   overflow_d;

  logic accept;
  logic push, push_code, push_ok, pop, full, wrap;
  logic p1_up_dir, p1_dn_dir, p2_up_dir, p2_dn_dir;

  assign accept = bus.valid && !valid_q;
  assign full   = (count_q == 3'd4);
  assign pop    = (count_q != 3'd0) && bus.evt_ready;
  assign wrap   = (tick_cnt_q == TICK_LAST);

  // Both keys held: the most recent make wins; otherwise the single held key.
  assign p1_up_dir = key_held_q[0] && (!key_held_q[1] || !p1_last_q);
  assign p1_dn_dir = key_held_q[1] && (!key_held_q[0] ||  p1_last_q);
  assign p2_up_dir = key_held_q[2] && (!key_held_q[3] || !p2_last_q);
  assign p2_dn_dir = key_held_q[3] && (!key_held_q[2] ||  p2_last_q);

  assign bus.key_held     = key_held_q;
  assign bus.p1_up_tick   = wrap && p1_up_dir;
  assign bus.p1_dn_tick   = wrap && p1_dn_dir;
  assign bus.p2_up_tick   = wrap && p2_up_dir;
  assign bus.p2_dn_tick   = wrap && p2_dn_dir;
  assign bus.evt_valid    = (count_q != 3'd0);
  assign bus.evt_code     = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : 1'b0;
  assign bus.evt_overflow = overflow_q;

  // Next-state: decoder FSM, prefix timeout, tick counter and event FIFO.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    key_held_d   = key_held_q;
    p1_last_d    = p1_last_q;
    p2_last_d    = p2_last_q;
    start_held_d = start_held_q;
    pause_held_d = pause_held_q;
    push         = 1'b0;
    push_code    = 1'b0;

    tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;

    // Prefix states give up after TIMEOUT idle cycles; no key action taken.
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (accept) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = IDLE;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.code == BRK_CODE) begin
            state_d = BRK;
          end else if (bus.code == EXT_CODE) begin
            state_d = EXT;
          end else begin
            case (bus.code)
              P1_UP_KEY: begin key_held_d[0] = 1'b1; p1_last_d = 1'b0; end
              P1_DN_KEY: begin key_held_d[1] = 1'b1; p1_last_d = 1'b1; end
              P2_UP_KEY: begin key_held_d[2] = 1'b1; p2_last_d = 1'b0; end
              P2_DN_KEY: begin key_held_d[3] = 1'b1; p2_last_d = 1'b1; end
              // Only the first make pushes; typematic repeats are filtered.
              START_KEY: begin
                push         = !start_held_q;
                push_code    = 1'b0;
                start_held_d = 1'b1;
              end
              PAUSE_KEY: begin
                push         = !pause_held_q;
                push_code    = 1'b1;
                pause_held_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        BRK: begin
          state_d = IDLE;
          case (bus.code)
            P1_UP_KEY: key_held_d[0] = 1'b0;
            P1_DN_KEY: key_held_d[1] = 1'b0;
            P2_UP_KEY: key_held_d[2] = 1'b0;
            P2_DN_KEY: key_held_d[3] = 1'b0;
            START_KEY: start_held_d  = 1'b0;
            PAUSE_KEY: pause_held_d  = 1'b0;
            default: ;
          endcase
        end
        EXT:     state_d = (bus.code == BRK_CODE) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // A full FIFO still accepts a push when the head is popped that cycle.
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    fifo_d     = fifo_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = push_code;
    end
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      tick_cnt_q   <= '0;
      valid_q      <= 1'b0;
      key_held_q   <= 4'b0000;
      p1_last_q    <= 1'b0;
      p2_last_q    <= 1'b0;
      start_held_q <= 1'b0;
      pause_held_q <= 1'b0;
      fifo_q       <= 4'b0000;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      valid_q      <= bus.valid;
      key_held_q   <= key_held_d;
      p1_last_q    <= p1_last_d;
      p2_last_q    <= p2_last_d;
      start_held_q <= start_held_d;
      pause_held_q <= pause_held_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: doc/ps2_input_sequencer.md
PS2_INPUT_SEQUENCER -- requirements
Module: ps2_input_sequencer

Interface
REQ-001 P1_UP_KEY, 8'h1D, player 1 up make code (W).
REQ-002 P1_DN_KEY, 8'h1B, player 1 down make code (S).
REQ-003 P2_UP_KEY, 8'h44, player 2 up make code (O).
REQ-004 P2_DN_KEY, 8'h4B, player 2 down make code (L).
REQ-005 START_KEY, 8'h29, start key make code (Space); PAUSE_KEY, 8'h4D, pause key make code (P).
REQ-006 TICK_COUNT, 12500000, clk cycles per movement tick (250 ms at 50 MHz).
REQ-007 TIMEOUT, 131072, clk cycles a prefix state may wait for its next byte.
REQ-008 clk  input  1  system clock, 50 MHz.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 code  input  8  scan code byte from the PS2 receiver.
REQ-011 valid  input  1  receiver byte-valid level; a new byte is the rising edge of valid.
REQ-012 key_held  output  4  pressed state {p2_dn, p2_up, p1_dn, p1_up}.
REQ-013 p1_up_tick, p1_dn_tick, p2_up_tick, p2_dn_tick  output  1 each  one-cycle movement pulses.
REQ-014 evt_valid  output  1  event FIFO non-empty.
REQ-015 evt_code  output  1  head event: 0 = START, 1 = PAUSE.
REQ-016 evt_ready  input  1  consumer pop; pop occurs on a clk edge with evt_valid && evt_ready.
REQ-017 evt_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-018 The block SHALL register valid into valid_d and accept a byte on the edge where valid=1 and valid_d=0; the accepted byte's effects SHALL be visible on the following cycle.
REQ-019 The decoder SHALL be an FSM with states IDLE, BRK, EXT, EXT_BRK.
REQ-020 IDLE: F0 -> BRK; E0 -> EXT; a mapped code sets its key_held bit (make); all other codes ignored, stay IDLE.
REQ-021 BRK: a mapped code clears its key_held bit; any byte -> IDLE.
REQ-022 EXT: F0 -> EXT_BRK; any other byte discarded -> IDLE.
REQ-023 EXT_BRK: any byte discarded -> IDLE; extended keys SHALL never affect key_held or events.
REQ-024 In BRK, EXT or EXT_BRK, a timeout counter SHALL count cycles without an accepted byte; at TIMEOUT-1 the FSM SHALL return to IDLE with no key action; the counter SHALL clear on every accepted byte and in IDLE.
REQ-025 Per player, a last-pressed register SHALL record the most recent make of that player's up or down key; when both keys are held the last-pressed direction wins; when one is held it wins; when none, no direction.
REQ-026 A free-running tick counter SHALL count 0..TICK_COUNT-1 and wrap; on the cycle it equals TICK_COUNT-1 each player's resolved direction tick SHALL pulse high for exactly one cycle.
REQ-027 At most one of up/down tick per player SHALL be high in any cycle.
REQ-028 A make of START_KEY or PAUSE_KEY in IDLE SHALL push one event only if that key was not already held (typematic repeats ignored); break clears the held state.
REQ-029 START/PAUSE held state SHALL be internal and not appear on key_held.
REQ-030 The event FIFO SHALL be 4 entries deep, first-in first-out, with 2-bit pointers wrapping modulo 4 and a 3-bit occupancy count 0..4.
REQ-031 Push when full without a same-cycle pop SHALL drop the event and set evt_overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-032 Pop when empty SHALL be ignored; evt_code SHALL be undefined-free (0) when empty.

Reset
REQ-033 While rst=1, FSM = IDLE; timeout, tick counter, FIFO pointers and count = 0; key_held = 0; last-pressed registers cleared; valid_d = 0; evt_valid, evt_overflow and all tick outputs = 0.
REQ-034 Reset asserted mid-sequence (e.g. in BRK) SHALL abandon the sequence; the first byte after release is decoded from IDLE.
REQ-035 evt_overflow SHALL clear only on reset.

Verification
REQ-036 Bytes 1D, then F0 1D: key_held = 4'b0001 after 1D, 4'b0000 after 1D break; p1_up_tick pulses at every wrap while held, none after.
REQ-037 1B held, then 1D pressed: p1_dn_tick pulses until 1D make, then only p1_up_tick; after F0 1D, p1_dn_tick resumes.
REQ-038 F0, then no byte for TIMEOUT cycles, then 1D: FSM back in IDLE before 1D; 1D treated as make, key_held[0] = 1.
REQ-039 E0 1D, then E0 F0 1D: key_held stays 0, FSM ends in IDLE.
REQ-040 Five START/PAUSE make-break pairs with evt_ready=0: evt_valid = 1, four events queued in order, evt_overflow = 1; popping four entries returns the first four codes in order, then evt_valid = 0.
REQ-041 29 29 29 (typematic) then F0 29: exactly one START event queued.
